// File: rtl/irq_controller.sv
// irq_controller
//
// Memory-mapped interrupt controller. It collects peripheral IRQ lines,
// latches requests, masks them per source, arbitrates by fixed priority
// (lowest index wins) and presents a single INTR/INTA/VECTOR handshake to
// the CPU. It shares the CPU data bus using the common tri-state read scheme.
//
// Register map (byte addresses):
//   BASE+0  PENDING  read, write-1-to-clear
//   BASE+4  ENABLE   read/write, low NUM_IRQ bits
//   BASE+8  STATUS   read {[9] spurious, [8] in-service, [VECBITS-1:0] VECTOR};
//                    any write is End-Of-Interrupt and clears spurious
//   BASE+12 OVERRUN  read, write-1-to-clear
//
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   ADDRBUS  CPU address
//   DATABUS  CPU data, driven only while a register is read
//   WE       write enable for the current ADDRBUS
//   IRQ_IN   source requests, bit 0 is the timer
//   INTA     CPU acknowledge, single-cycle pulse
//   INTR     registered interrupt request to the CPU
//   VECTOR   index of the source in service
//
// Build option:
//   IRQC_LEVEL_EN  when defined, sources are level-sensitive: PENDING mirrors
//                  IRQ_IN one cycle late, PENDING writes and INTA do not clear
//                  it, and OVERRUN always reads 0. When undefined, requests
//                  are latched on rising edges.

module irq_controller #(
  parameter int                BITS    = 32,
  parameter int                NUM_IRQ = 4,
  parameter int                VECBITS = 4,
  parameter logic [BITS-1:0]   BASE    = 32'hFFFF0300
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [BITS-1:0]    ADDRBUS,
  inout  wire  [BITS-1:0]    DATABUS,
  input  logic               WE,
  input  logic [NUM_IRQ-1:0] IRQ_IN,
  input  logic               INTA,
  output logic               INTR,
  output logic [VECBITS-1:0] VECTOR
);

  localparam logic [BITS-1:0] ADDR_PEND = BASE;
  localparam logic [BITS-1:0] ADDR_EN   = BASE + BITS'(4);
  localparam logic [BITS-1:0] ADDR_STAT = BASE + BITS'(8);
  localparam logic [BITS-1:0] ADDR_OVR  = BASE + BITS'(12);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [NUM_IRQ-1:0]   pending_reg, pending_next;
  logic [NUM_IRQ-1:0]   enable_reg, enable_next;
  logic [NUM_IRQ-1:0]   overrun_reg, overrun_next;
  logic                 in_service_reg, in_service_next;
  logic                 spurious_reg, spurious_next;
  logic [VECBITS-1:0]   vector_reg, vector_next;
  logic                 intr_reg, intr_next;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic                 hit_pend, hit_en, hit_stat, hit_ovr, hit_any;
  logic                 wr_pend, wr_en, wr_stat, wr_ovr;
  logic [NUM_IRQ-1:0]   wdata_irq;
  logic [BITS-1:0]      rd_data;

  assign hit_pend  = (ADDRBUS == ADDR_PEND);
  assign hit_en    = (ADDRBUS == ADDR_EN);
  assign hit_stat  = (ADDRBUS == ADDR_STAT);
  assign hit_ovr   = (ADDRBUS == ADDR_OVR);
  assign hit_any   = hit_pend | hit_en | hit_stat | hit_ovr;

  assign wr_pend   = WE & hit_pend;
  assign wr_en     = WE & hit_en;
  assign wr_stat   = WE & hit_stat;
  assign wr_ovr    = WE & hit_ovr;

  // Only the low NUM_IRQ data bits carry meaning on writes.
  assign wdata_irq = DATABUS[NUM_IRQ-1:0];

  always_comb begin
    rd_data = '0;
    if (hit_pend) begin
      rd_data[NUM_IRQ-1:0] = pending_reg;
    end else if (hit_en) begin
      rd_data[NUM_IRQ-1:0] = enable_reg;
    end else if (hit_stat) begin
      rd_data[VECBITS-1:0] = vector_reg;
      rd_data[8]           = in_service_reg;
      rd_data[9]           = spurious_reg;
    end else if (hit_ovr) begin
      rd_data[NUM_IRQ-1:0] = overrun_reg;
    end
  end

  // Released while in reset so the bus is never driven with stale data.
  assign DATABUS = (RESET_N && !WE && hit_any) ? rd_data : {BITS{1'bz}};

  // ---------------------------------------------------------------------
  // Arbitration: lowest set bit of the candidate set wins.
  // ---------------------------------------------------------------------
  logic [NUM_IRQ-1:0]   cand;
  logic                 cand_any;
  logic [NUM_IRQ-1:0]   winner_onehot;
  logic [VECBITS-1:0]   winner;

  assign cand          = pending_reg & enable_reg;
  assign cand_any      = |cand;
  // Two's-complement trick isolates the lowest set bit.
  assign winner_onehot = cand & (~cand + NUM_IRQ'(1));

  always_comb begin
    winner = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        winner = VECBITS'(k);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  logic ack_take;  // INTA accepted in REQ: latch the winner, clear its bit

  always_comb begin
    state_next      = state_reg;
    intr_next       = intr_reg;
    vector_next     = vector_reg;
    in_service_next = in_service_reg;
    spurious_next   = spurious_reg;
    ack_take        = 1'b0;

    // A STATUS write clears spurious; a spurious INTA in the same cycle
    // below re-sets it, so the newer event is not lost.
    if (wr_stat) begin
      spurious_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        intr_next = 1'b0;
        if (INTA) begin
          spurious_next = 1'b1;
        end
        if (cand_any) begin
          state_next = REQ;
          intr_next  = 1'b1;
        end
      end

      REQ: begin
        if (!cand_any) begin
          // Request withdrawn (masked or cleared); an INTA racing the
          // withdrawal has nothing to acknowledge.
          state_next = IDLE;
          intr_next  = 1'b0;
          if (INTA) begin
            spurious_next = 1'b1;
          end
        end else if (INTA) begin
          ack_take        = 1'b1;
          state_next      = SERVICE;
          vector_next     = winner;
          in_service_next = 1'b1;
          intr_next       = 1'b0;
        end
      end

      SERVICE: begin
        // No nesting: new requests stay pending until EOI.
        intr_next = 1'b0;
        if (wr_stat) begin
          state_next      = IDLE;
          in_service_next = 1'b0;
        end
      end

      default: begin
        state_next = IDLE;
        intr_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Per-source request latching
  // ---------------------------------------------------------------------
  assign enable_next = wr_en ? wdata_irq : enable_reg;

`ifdef IRQC_LEVEL_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      assign pending_next[gi] = IRQ_IN[gi];
      assign overrun_next[gi] = 1'b0;
    end
  endgenerate
`else
  // History starts at all ones so a line already high at reset release
  // is not mistaken for a new edge.
  logic [NUM_IRQ-1:0] irq_prev_reg;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      irq_prev_reg <= '1;
    end else begin
      irq_prev_reg <= IRQ_IN;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
      logic rise;
      logic clr;
      assign rise = IRQ_IN[gi] & ~irq_prev_reg[gi];
      assign clr  = (wr_pend & wdata_irq[gi]) | (ack_take & winner_onehot[gi]);
      // A new edge beats a same-cycle clear, and such a bit does not
      // count as an overrun because the old request was consumed.
      assign pending_next[gi] = rise | (pending_reg[gi] & ~clr);
      assign overrun_next[gi] = (rise & pending_reg[gi] & ~clr)
                              | (overrun_reg[gi] & ~(wr_ovr & wdata_irq[gi]));
    end
  endgenerate
`endif

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      enable_reg     <= '0;
      overrun_reg    <= '0;
      in_service_reg <= 1'b0;
      spurious_reg   <= 1'b0;
      vector_reg     <= '0;
      intr_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      enable_reg     <= enable_next;
      overrun_reg    <= overrun_next;
      in_service_reg <= in_service_next;
      spurious_reg   <= spurious_next;
      vector_reg     <= vector_next;
      intr_reg       <= intr_next;
    end
  end

  assign INTR   = intr_reg;
  assign VECTOR = vector_reg;

endmodule
